// File: rtl/mux_n_reg.sv
// mux_n_reg
//
// Registered N-way data selector with a valid/ready handshake on both sides.
// Each accepted transfer picks one WIDTH-bit word out of the packed in_data
// bus and delivers it one cycle later on out_data. Two storage slots (an
// output register plus one skid register) let in_ready come straight from a
// flop, so it never depends combinationally on out_ready, while streaming
// still runs at one word per cycle.
//
// Parameters
//   WIDTH  - bits per data word (each input and the output)
//   N_IN   - number of data inputs, 2..16
//   SEL_W  - select width, normally ceil(log2(N_IN)); it may be wider
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst        in   asynchronous active-high reset
//   in_data    in   N_IN packed words, word k at [k*WIDTH +: WIDTH]
//   sel        in   index of the word to pick, sampled on accept
//   in_valid   in   producer offers in_data/sel
//   in_ready   out  skid slot free, so a transfer can be accepted
//   flush      in   synchronous discard of everything held
//   out_data   out  selected word, registered
//   out_sel    out  effective index that produced out_data
//   out_valid  out  out_data holds an undelivered word
//   out_ready  in   consumer takes out_data this cycle
//   sel_err    out  sticky: an out-of-range select was accepted

module mux_n_reg #(
    parameter int WIDTH = 32,
    parameter int N_IN  = 4,
    parameter int SEL_W = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_IN*WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    localparam logic [31:0] N_IN_U = N_IN;

    logic [WIDTH-1:0] skid_data;
    logic [SEL_W-1:0] skid_sel;
    logic             skid_valid;

    logic             sel_oob;
    logic [SEL_W-1:0] eff_sel;
    logic [WIDTH-1:0] sel_word;
    logic             accept;
    logic             drain;

    // The accept handshake only looks at the skid slot, which keeps
    // in_ready a registered signal gated by reset.
    assign in_ready = ~skid_valid & ~rst;
    assign accept   = in_valid & in_ready;
    assign drain    = out_valid & out_ready;

    // Select decode: an out-of-range index falls back to input 0, and the
    // fallback index is what travels with the word as out_sel. The mux is a
    // priority loop rather than a variable part-select so that no index
    // ever reaches beyond the N_IN words, whatever SEL_W is.
    always_comb begin
        sel_oob  = ({{(32-SEL_W){1'b0}}, sel} >= N_IN_U);
        eff_sel  = sel_oob ? '0 : sel;
        sel_word = in_data[WIDTH-1:0];
        for (int k = 1; k < N_IN; k++) begin
            if (eff_sel == SEL_W'(k)) begin
                sel_word = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Output register and skid register. Flush wins over everything and
    // only drops the valid bits, leaving the last data/index visible.
    // When the output slot is free or emptying, it refills from the skid
    // first so ordering stays first-in first-out; the skid can only be
    // occupied while in_ready is low, so no accept competes with it then.
    // A word accepted while the output slot is stalled parks in the skid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data   <= '0;
            out_sel    <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_sel   <= '0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || drain) begin
            if (skid_valid) begin
                out_data   <= skid_data;
                out_sel    <= skid_sel;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_data   <= sel_word;
                out_sel    <= eff_sel;
                out_valid  <= 1'b1;
            end else begin
                out_valid  <= 1'b0;
            end
        end else if (accept) begin
            skid_data  <= sel_word;
            skid_sel   <= eff_sel;
            skid_valid <= 1'b1;
        end
    end

    // Sticky select-error flag: any accepted out-of-range select sets it,
    // and only reset clears it. A flush discards the word but the fact
    // that a bad select was presented is still recorded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_err <= 1'b0;
        end else if (accept && sel_oob) begin
            sel_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_n_reg.sv
// tb_mux_n_reg
//
// Self-checking bench for mux_n_reg with WIDTH=32, N_IN=4 and a 3-bit
// select so that out-of-range indices can be driven. A scoreboard queue
// receives the expected word whenever a transfer in happens and is popped
// whenever a transfer out happens; directed checks cover reset, latency,
// back-pressure, flush and asynchronous reset behaviour.

module tb_mux_n_reg;

    localparam int WIDTH = 32;
    localparam int N_IN  = 4;
    localparam int SEL_W = 3;

    logic                  clk;
    logic                  rst;
    logic [N_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]      sel;
    logic                  in_valid;
    logic                  in_ready;
    logic                  flush;
    logic [WIDTH-1:0]      out_data;
    logic [SEL_W-1:0]      out_sel;
    logic                  out_valid;
    logic                  out_ready;
    logic                  sel_err;

    int error_count = 0;
    int check_count = 0;

    logic [SEL_W+WIDTH-1:0] scoreboard [$];
    logic [SEL_W+WIDTH-1:0] expected_entry;

    mux_n_reg #(
        .WIDTH (WIDTH),
        .N_IN  (N_IN),
        .SEL_W (SEL_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Reference selection: in-range index picks that word, anything else
    // falls back to word 0 reported with index 0.
    function automatic logic [SEL_W+WIDTH-1:0] modelSelect(
        input logic [N_IN*WIDTH-1:0] d, input logic [SEL_W-1:0] s);
        logic [WIDTH-1:0] w;
        if (int'(s) < N_IN) begin
            w = d[int'(s)*WIDTH +: WIDTH];
            return {s, w};
        end
        w = d[WIDTH-1:0];
        return {{SEL_W{1'b0}}, w};
    endfunction

    // Scoreboard monitor, sampling on the falling edge so the values seen
    // are the ones the next rising edge will act on.
    always @(negedge clk) begin
        if (rst) begin
            scoreboard.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (scoreboard.size() == 0) begin
                    checkOutput("sb_spurious_out", 64'd1, 64'd0);
                end else begin
                    expected_entry = scoreboard.pop_front();
                    checkOutput("sb_data", 64'(out_data), 64'(expected_entry[WIDTH-1:0]));
                    checkOutput("sb_sel", 64'(out_sel), 64'(expected_entry[SEL_W+WIDTH-1:WIDTH]));
                end
            end
            if (flush) begin
                scoreboard.delete();
            end else if (in_valid && in_ready) begin
                scoreboard.push_back(modelSelect(in_data, sel));
            end
        end
    end

    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one offered word: background pattern on every input, then the
    // chosen slot overwritten with the given value.
    task automatic applyStimulus(input logic [SEL_W-1:0] s, input int slot,
                                 input logic [WIDTH-1:0] word);
        for (int k = 0; k < N_IN; k++) begin
            in_data[k*WIDTH +: WIDTH] = 32'hF000_0000 | 32'(k);
        end
        in_data[slot*WIDTH +: WIDTH] = word;
        sel      = s;
        in_valid = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        sel       = '0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #2;
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_data", 64'(out_data), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_sel_err", 64'(sel_err), 64'd0);
        cycle(2);
        rst = 1'b0;
        cycle(1);
        checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Single word, one-cycle latency
        out_ready = 1'b1;
        applyStimulus(3'd2, 2, 32'hDEADBEEF);
        cycle(1);
        in_valid = 1'b0;
        checkOutput("lat_out_valid", 64'(out_valid), 64'd1);
        checkOutput("lat_out_data", 64'(out_data), 64'hDEADBEEF);
        checkOutput("lat_out_sel", 64'(out_sel), 64'd2);
        cycle(1);
        checkOutput("lat_one_cycle", 64'(out_valid), 64'd0);

        // Back-to-back streaming at full throughput
        for (int i = 0; i < 4; i++) begin
            applyStimulus(SEL_W'(i), i, 32'h10 + 32'(i));
            checkOutput("stream_in_ready", 64'(in_ready), 64'd1);
            cycle(1);
            checkOutput("stream_out_valid", 64'(out_valid), 64'd1);
            checkOutput("stream_out_data", 64'(out_data), 64'h10 + 64'(i));
        end
        in_valid = 1'b0;
        cycle(1);
        checkOutput("stream_done", 64'(out_valid), 64'd0);

        // Back-pressure: two words fill both slots
        out_ready = 1'b0;
        applyStimulus(3'd0, 0, 32'h1);
        cycle(1);
        applyStimulus(3'd1, 1, 32'h2);
        cycle(1);
        in_valid = 1'b0;
        checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
        checkOutput("bp_hold_a", 64'(out_data), 64'h1);
        cycle(3);
        checkOutput("bp_still_a", 64'(out_data), 64'h1);
        checkOutput("bp_still_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        cycle(1);
        checkOutput("bp_then_b", 64'(out_data), 64'h2);
        checkOutput("bp_ready_back", 64'(in_ready), 64'd1);
        cycle(1);
        checkOutput("bp_drained", 64'(out_valid), 64'd0);

        // Out-of-range select falls back to input 0
        applyStimulus(3'd5, 0, 32'hAAAA);
        cycle(1);
        in_valid = 1'b0;
        checkOutput("oob_out_data", 64'(out_data), 64'hAAAA);
        checkOutput("oob_out_sel", 64'(out_sel), 64'd0);
        checkOutput("oob_sel_err", 64'(sel_err), 64'd1);
        out_ready = 1'b0;
        flush = 1'b1;
        cycle(1);
        flush = 1'b0;
        checkOutput("oob_err_sticky", 64'(sel_err), 64'd1);

        // Flush with both slots full and a word offered
        applyStimulus(3'd3, 3, 32'h33);
        cycle(1);
        applyStimulus(3'd1, 1, 32'h44);
        cycle(1);
        checkOutput("fl_full", 64'(in_ready), 64'd0);
        applyStimulus(3'd2, 2, 32'h55);
        flush = 1'b1;
        cycle(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("fl_out_valid", 64'(out_valid), 64'd0);
        checkOutput("fl_in_ready", 64'(in_ready), 64'd1);
        checkOutput("fl_data_kept", 64'(out_data), 64'h33);
        out_ready = 1'b1;
        cycle(3);
        checkOutput("fl_nothing_emerges", 64'(out_valid), 64'd0);

        // Flush with skid empty discards the word accepted on that edge
        out_ready = 1'b0;
        applyStimulus(3'd1, 1, 32'h66);
        cycle(1);
        applyStimulus(3'd2, 2, 32'h77);
        flush = 1'b1;
        cycle(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("fl_accept_dropped", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        cycle(2);
        checkOutput("fl_accept_gone", 64'(out_valid), 64'd0);

        // Asynchronous reset between edges
        out_ready = 1'b0;
        applyStimulus(3'd3, 3, 32'h99);
        cycle(1);
        in_valid = 1'b0;
        checkOutput("ar_pre_valid", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("ar_out_valid", 64'(out_valid), 64'd0);
        checkOutput("ar_out_data", 64'(out_data), 64'd0);
        checkOutput("ar_in_ready", 64'(in_ready), 64'd0);
        checkOutput("ar_sel_err_clr", 64'(sel_err), 64'd0);
        cycle(2);
        rst = 1'b0;
        out_ready = 1'b1;
        applyStimulus(3'd1, 1, 32'hBEEF);
        cycle(1);
        in_valid = 1'b0;
        checkOutput("ar_first_accept", 64'(out_valid), 64'd1);
        checkOutput("ar_first_data", 64'(out_data), 64'hBEEF);

        // Randomised streaming with random back-pressure
        for (int i = 0; i < 200; i++) begin
            if (in_ready || !in_valid) begin
                if ($urandom_range(0, 3) != 0) begin
                    applyStimulus(SEL_W'($urandom_range(0, 7)),
                                  int'($urandom_range(0, N_IN-1)), $urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 2) != 0);
            cycle(1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycle(4);
        checkOutput("sb_empty", 64'(scoreboard.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule

// File: doc/mux_n_reg.md
MUX_N_REG -- requirements
Module: mux_n_reg

Interface
REQ-001 Parameter WIDTH, default 32, data width of each input and of the output, in bits.
REQ-002 Parameter N_IN, default 4, number of data inputs; legal range 2..16.
REQ-003 Parameter SEL_W, default 2, select width; the instantiator sets it to ceil(log2(N_IN)).
REQ-004 Port clk, input, 1 bit, the single clock; all state changes on the rising edge.
REQ-005 Port rst, input, 1 bit, reset; asynchronous and active-high.
REQ-006 Port in_data, input, N_IN*WIDTH bits, packed inputs; input k occupies bits [k*WIDTH+WIDTH-1 : k*WIDTH].
REQ-007 Port sel, input, SEL_W bits, input index, sampled together with in_data on accept.
REQ-008 Port in_valid, input, 1 bit, producer has in_data/sel ready for transfer.
REQ-009 Port in_ready, output, 1 bit, block can accept a transfer this cycle.
REQ-010 Port flush, input, 1 bit, synchronous discard of all held data.
REQ-011 Port out_data, output, WIDTH bits, selected data, registered.
REQ-012 Port out_sel, output, SEL_W bits, effective index that produced out_data.
REQ-013 Port out_valid, output, 1 bit, out_data holds an undelivered result.
REQ-014 Port out_ready, input, 1 bit, consumer accepts out_data this cycle.
REQ-015 Port sel_err, output, 1 bit, sticky flag: an out-of-range select was accepted.

Function
REQ-016 A transfer in SHALL occur on a rising edge where in_valid=1 and in_ready=1; a transfer out SHALL occur where out_valid=1 and out_ready=1.
REQ-017 The selected word SHALL be input[sel] when sel < N_IN; when sel >= N_IN it SHALL be input 0, with out_sel=0.
REQ-018 Latency SHALL be exactly one cycle: data accepted at edge t appears on out_data with out_valid=1 after edge t, when the output stage is empty or draining.
REQ-019 The block SHALL hold two entries: an output register and one skid register.
REQ-020 in_ready SHALL be 1 exactly when the skid register is empty and rst=0; in_ready SHALL not depend combinationally on out_ready.
REQ-021 If the output register is empty or drains this edge, it SHALL load from the skid register when the skid is occupied, otherwise from the accepted input.
REQ-022 When an accept occurs while the output register is occupied and not draining, the accepted word SHALL go to the skid register.
REQ-023 Ordering SHALL be strictly first-in first-out; no word is dropped or duplicated except by flush.
REQ-024 While out_valid=1 and out_ready=0, out_data and out_sel SHALL hold stable.
REQ-025 flush=1 SHALL clear out_valid and the skid register at that edge; an input accepted on the same edge SHALL be discarded; flush has priority over every other update.
REQ-026 out_data and out_sel SHALL keep their last values when flushed; only out_valid clears.
REQ-027 sel_err SHALL set on the edge that accepts a word with sel >= N_IN, and SHALL clear only on reset; flush does not clear it.
REQ-028 Simultaneous drain and accept with the skid empty SHALL load the new word into the output register with out_valid remaining 1, giving full throughput.

Reset
REQ-029 While rst=1: out_data=0, out_sel=0, out_valid=0, skid empty, sel_err=0, in_ready=0, asynchronously.
REQ-030 Reset asserted mid-transfer SHALL discard both entries; the first edge after release with in_valid=1 SHALL be accepted normally.

Verification
REQ-031 N_IN=4: sel=2, input2=0xDEADBEEF, in_valid pulse, out_ready=1 -> next cycle out_data=0xDEADBEEF, out_sel=2, out_valid=1 for one cycle.
REQ-032 Back-to-back streaming of sel=0,1,2,3 with inputs 0x10..0x13 and out_ready=1 -> outputs 0x10,0x11,0x12,0x13 on consecutive cycles, in_ready held 1.
REQ-033 out_ready=0 with two words A=0x1, B=0x2 accepted -> in_ready drops to 0 after B; out_data holds A; on out_ready=1, A then B delivered in order.
REQ-034 sel=5 with N_IN=4, input0=0xAAAA -> out_data=0xAAAA, out_sel=0, sel_err=1; sel_err remains 1 after flush and clears only on rst.
REQ-035 Skid full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, no word later emerges.
REQ-036 rst asserted between edges with out_valid=1 -> out_valid=0 and out_data=0 immediately, before the next clock edge.
